// File: rtl/ram_port_arbiter.sv
// Shares one synchronous RAM port among N_CH masters with a req/gnt handshake and a registered read strobe.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin selection; the default build uses fixed lowest-index priority.
module ram_port_arbiter #(
  parameter int N_CH   = 3,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          we,
  input  logic [N_CH*ADDR_W-1:0]   addr,
  input  logic [N_CH*DATA_W-1:0]   wdata,
  output logic [N_CH-1:0]          gnt,
  output logic [N_CH-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        ram_address,
  output logic [DATA_W-1:0]        ram_data,
  output logic                     ram_wren,
  input  logic [DATA_W-1:0]        ram_q
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PW-1:0] last;
  logic [PW-1:0] gidx;
  logic          any;
  int            d;
  int            best_d;

  // Each requester gets a distance from the search start; the smallest distance wins.
  always_comb begin
    gidx   = '0;
    any    = 1'b0;
    best_d = N_CH;
    d      = 0;
    for (int c = 0; c < N_CH; c++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      d = (c - int'(last) - 1 + 2 * N_CH) % N_CH;
`else
      d = c;
`endif
      if (clear && req[c] && (d < best_d)) begin
        best_d = d;
        gidx   = PW'(c);
        any    = 1'b1;
      end
    end
  end

`ifndef RAM_ARB_ROUND_ROBIN_EN
  // Pointer is kept for debug visibility only in the fixed-priority build.
  logic last_unused;
  assign last_unused = ^last;
`endif

  always_comb begin
    gnt = '0;
    for (int c = 0; c < N_CH; c++)
      gnt[c] = any && (gidx == PW'(c));
  end

  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (gnt[c]) begin
        ram_address = addr[c*ADDR_W +: ADDR_W];
        ram_data    = wdata[c*DATA_W +: DATA_W];
        ram_wren    = we[c];
      end
    end
  end

  // Reset clears the strobe asynchronously, so a read in flight is dropped.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      last   <= PW'(N_CH - 1);
      rvalid <= '0;
    end else begin
      rvalid <= gnt & ~we;
      if (any) last <= gidx;
    end
  end

  assign rdata = ram_q;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Parametrised N-channel arbiter that shares one synchronous RAM port among several masters (CPU data path, VGA fetch, future DMA). It replaces the fixed one-master-per-port wiring of the dual-port RAM. Each master gets a req/gnt handshake and a one-cycle read-return strobe. It sits between the masters and one `address/data/wren/q` port of the RAM IP, in the RAM's clock domain.

## Interface
- `N_CH`, 3: number of master channels (1..8).
- `ADDR_W`, 16: RAM word-address width.
- `DATA_W`, 16: RAM data width.

- `clock`  in  1  RAM-domain clock; all state changes on the rising edge.
- `clear`  in  1  reset; asynchronous, active-low.
- `req`  in  N_CH  per-channel access request.
- `we`  in  N_CH  per-channel write enable; 1 = write, 0 = read.
- `addr`  in  N_CH*ADDR_W  channel i at `[i*ADDR_W +: ADDR_W]`.
- `wdata`  in  N_CH*DATA_W  channel i at `[i*DATA_W +: DATA_W]`.
- `gnt`  out  N_CH  one-hot grant; combinational from `req` and arbiter state.
- `rvalid`  out  N_CH  registered read-return strobe, one per channel.
- `rdata`  out  DATA_W  shared read data; pass-through of `ram_q`.
- `ram_address`  out  ADDR_W  to RAM address port.
- `ram_data`  out  DATA_W  to RAM data port.
- `ram_wren`  out  1  to RAM write enable.
- `ram_q`  in  DATA_W  from RAM q port (unregistered output, address registered inside RAM).

## Operation
- Each cycle the arbiter grants at most one channel with `req`=1. `gnt` is 0 when no channel requests.
- A transfer completes on the rising edge where `req[i] & gnt[i]`.
- The master holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`. It may drop `req` or issue a new request in the cycle after the grant.
- RAM mux is combinational from the granted channel:
  - `ram_address = addr[g]`.
  - `ram_data = wdata[g]`.
  - `ram_wren = we[g]`.
  - When idle, all three are 0.
- Read return:
  - `rvalid[i]` is registered as `gnt[i] & ~we[i]`.
  - `rdata` is meaningful only in a cycle where some `rvalid` bit is 1.
- Arbiter state: `last` (index of the most recently granted channel, `$clog2(N_CH)` bits, minimum 1). It updates on every grant and holds when idle.
- Back-to-back grants to different channels are legal every cycle; the RAM port sustains one access per cycle.
- Write at T followed by a read of the same address at T+1 returns the new data. This is RAM semantics; the arbiter adds no forwarding.
- `N_CH`=1 degenerates to `gnt = req & clear`, with the pointer unused.

## Timing
- Reset values while `clear`=0:
  - `gnt`=0 (forced combinationally).
  - `rvalid`=0.
  - `ram_wren`=0, `ram_address`=0, `ram_data`=0.
  - `last`=N_CH-1, so channel 0 has top priority after release.
- `rdata` is not reset; it follows `ram_q`.
- Latency:
  - Grant is available in the same cycle as `req` if that channel wins.
  - Read data is returned one cycle after the grant (T grant → T+1 `rvalid`, `rdata`).
  - A write completes at the grant edge.
- Reset asserted mid-read (grant at T, `clear` falls during T+1): `rvalid` drops immediately and that read is lost. The master must reissue the read after release.
- Simultaneous requests are resolved per the Configuration section. A losing channel keeps `req` high and waits; no request is dropped by the arbiter.
- `req` without `gnt` has no side effect on the RAM.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration. The search starts at `(last+1) mod N_CH` and wraps.
  - Any continuously requesting channel is granted within N_CH cycles.
- Undefined:
  - Fixed priority; the lowest requesting index wins.
  - `last` is still maintained for debug but does not affect selection.
  - Starvation of higher indices is allowed by design.

## Test plan
- Reset: hold `clear`=0 with all `req`=1 → `gnt`=0, `rvalid`=0, `ram_wren`=0, `ram_address`=0 every cycle.
- Write then read:
  - ch2 writes 0x1234 to 0x00FF → `gnt`=3'b100, `ram_wren`=1, `ram_address`=0x00FF, `ram_data`=0x1234, no `rvalid`.
  - ch1 then reads 0x00FF → `rvalid`=3'b010 next cycle with `rdata`=0x1234.
- Contention, round-robin build: all three channels request reads continuously from reset → `gnt` sequence 001, 010, 100, 001, …; each `rvalid` bit follows its grant by one cycle.
- Contention, fixed-priority build: same stimulus → `gnt`=001 every cycle, and ch1/ch2 never granted. Drop `req[0]` → `gnt`=010 in the same cycle.
- Reset mid-read: ch1 read granted at T, `clear` pulsed low during T+1 → `rvalid[1]`=0 at T+1. After release with all channels requesting, the first grant is 001.
- Idle gaps: alternate `req[0]` on/off every cycle, others idle → grant only in request cycles, `ram_address`=0 and `ram_wren`=0 in gap cycles, and `last` unchanged across gaps.
